// File: rtl/freq_det_pkg.sv
// Shared constants, state encoding and expected-period helper for the frequency detector.
// Used by frecuencia_detector (optional feature macro: FREQ_DET_DUTY_EN).
package freq_det_pkg;

    localparam int unsigned NUM_BINS  = 8;
    localparam int unsigned BASE_HZ   = 25000;
    localparam int unsigned WIN_SHIFT = 5;
    localparam int unsigned SEL_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    // Expected period in clk cycles of the k-th divider frequency (k = 1..NUM_BINS).
    function automatic int unsigned exp_period(input int unsigned clk_hz, input int unsigned k);
        return clk_hz / (k * BASE_HZ);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input followed by a registered rising-edge pulse.
// The level output is delayed to line up with the rise pulse.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic meta_r;
    logic sync_r;
    logic dly_r;
    logic rise_r;

    // Synchronizer chain and edge pulse register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            dly_r  <= 1'b0;
            rise_r <= 1'b0;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
            dly_r  <= sync_r;
            rise_r <= sync_r & ~dly_r;
        end
    end

    assign level = dly_r;
    assign rise  = rise_r;

endmodule

// File: rtl/frecuencia_detector.sv
// Square-wave frequency detector: measures the input period and locks onto one of eight
// k*25 kHz bins. Optional high-time measurement enabled by defining FREQ_DET_DUTY_EN.
module frecuencia_detector
    import freq_det_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned TIMEOUT  = 10000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             bin_hit,
    output logic [SEL_W-1:0] freq_sel,
    output logic             locked,
    output logic             no_signal
`ifdef FREQ_DET_DUTY_EN
    ,
    output logic [CNT_W-1:0] duty_hi
`endif
);

    localparam int unsigned      MW        = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [MW-1:0]    LOCK_C    = MW'(LOCK_CNT);

    logic                level_s;
    logic                rise_s;
    logic [31:0]         cnt_ext_s;
    logic [NUM_BINS-1:0] in_win_s;
    logic                hit_s;
    logic [SEL_W-1:0]    bin_s;
    logic [MW-1:0]       acq_cnt_s;
    logic [MW-1:0]       mis_cnt_s;

    state_e           state_r,  state_n;
    logic [CNT_W-1:0] cnt_r,    cnt_n;
    logic [MW-1:0]    match_r,  match_n;
    logic [MW-1:0]    miss_r,   miss_n;
    logic [SEL_W-1:0] cand_r,   cand_n;
    logic [CNT_W-1:0] period_r, period_n;
    logic             vld_r,    vld_n;
    logic             hit_r,    hit_n;
    logic [SEL_W-1:0] sel_r,    sel_n;
    logic             locked_r, locked_n;
    logic             nosig_r,  nosig_n;

    sync_edge_det u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (sig_in),
        .level    (level_s),
        .rise     (rise_s)
    );

    assign cnt_ext_s = 32'(cnt_r);

    // One tolerance window per bin; windows are disjoint so at most one bit is set.
    for (genvar g = 0; g < NUM_BINS; g++) begin : g_bin
        localparam int unsigned PK  = exp_period(CLK_HZ, 32'(g) + 32'd1);
        localparam int unsigned WIN = PK >> WIN_SHIFT;
        assign in_win_s[g] = (cnt_ext_s >= (PK - WIN)) && (cnt_ext_s <= (PK + WIN));
    end

    // Encode the hitting bin index.
    always_comb begin
        hit_s = |in_win_s;
        bin_s = {SEL_W{1'b0}};
        for (int i = 0; i < NUM_BINS; i++) begin
            bin_s = in_win_s[i] ? SEL_W'(i) : bin_s;
        end
    end

    // Candidate run length while acquiring and miss run length while locked.
    always_comb begin
        acq_cnt_s = {MW{1'b0}};
        mis_cnt_s = {MW{1'b0}};
        if (!hit_s) begin
            acq_cnt_s = {MW{1'b0}};
        end else if (bin_s == cand_r) begin
            acq_cnt_s = match_r + 1'b1;
        end else begin
            acq_cnt_s = MW'(1);
        end
        if (hit_s && (bin_s == sel_r)) begin
            mis_cnt_s = {MW{1'b0}};
        end else begin
            mis_cnt_s = miss_r + 1'b1;
        end
    end

    // Next-state logic: period capture, classification outputs and lock FSM.
    always_comb begin
        state_n  = state_r;
        cnt_n    = cnt_r;
        match_n  = match_r;
        miss_n   = miss_r;
        cand_n   = cand_r;
        period_n = period_r;
        vld_n    = 1'b0;
        hit_n    = hit_r;
        sel_n    = sel_r;
        locked_n = locked_r;
        nosig_n  = nosig_r;
        if (rise_s) begin
            // An edge always beats a coincident timeout.
            cnt_n   = CNT_W'(1);
            nosig_n = 1'b0;
            case (state_r)
                ST_IDLE: begin
                    state_n = ST_ACQUIRE;
                    match_n = {MW{1'b0}};
                    miss_n  = {MW{1'b0}};
                end
                ST_ACQUIRE: begin
                    period_n = cnt_r;
                    vld_n    = 1'b1;
                    hit_n    = hit_s;
                    cand_n   = hit_s ? bin_s : cand_r;
                    if (acq_cnt_s == LOCK_C) begin
                        state_n  = ST_LOCKED;
                        sel_n    = bin_s;
                        locked_n = 1'b1;
                        match_n  = {MW{1'b0}};
                        miss_n   = {MW{1'b0}};
                    end else begin
                        match_n = acq_cnt_s;
                    end
                end
                ST_LOCKED: begin
                    period_n = cnt_r;
                    vld_n    = 1'b1;
                    hit_n    = hit_s;
                    if (mis_cnt_s == LOCK_C) begin
                        state_n  = ST_ACQUIRE;
                        locked_n = 1'b0;
                        miss_n   = {MW{1'b0}};
                        match_n  = {MW{1'b0}};
                    end else begin
                        miss_n = mis_cnt_s;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end else if (cnt_r >= TIMEOUT_C) begin
            state_n  = ST_IDLE;
            cnt_n    = {CNT_W{1'b0}};
            match_n  = {MW{1'b0}};
            miss_n   = {MW{1'b0}};
            locked_n = 1'b0;
            nosig_n  = 1'b1;
        end else begin
            cnt_n = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            match_r  <= {MW{1'b0}};
            miss_r   <= {MW{1'b0}};
            cand_r   <= {SEL_W{1'b0}};
            period_r <= {CNT_W{1'b0}};
            vld_r    <= 1'b0;
            hit_r    <= 1'b0;
            sel_r    <= {SEL_W{1'b0}};
            locked_r <= 1'b0;
            nosig_r  <= 1'b0;
        end else begin
            state_r  <= state_n;
            cnt_r    <= cnt_n;
            match_r  <= match_n;
            miss_r   <= miss_n;
            cand_r   <= cand_n;
            period_r <= period_n;
            vld_r    <= vld_n;
            hit_r    <= hit_n;
            sel_r    <= sel_n;
            locked_r <= locked_n;
            nosig_r  <= nosig_n;
        end
    end

`ifdef FREQ_DET_DUTY_EN
    logic [CNT_W-1:0] hi_cnt_r;
    logic [CNT_W-1:0] duty_r;

    // High-time counter; the edge cycle itself is already high and starts the new count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_cnt_r <= {CNT_W{1'b0}};
            duty_r   <= {CNT_W{1'b0}};
        end else if (rise_s) begin
            if (state_r != ST_IDLE) begin
                duty_r <= hi_cnt_r;
            end
            hi_cnt_r <= CNT_W'(1);
        end else if (level_s && (hi_cnt_r != CNT_MAX)) begin
            hi_cnt_r <= hi_cnt_r + 1'b1;
        end
    end

    assign duty_hi = duty_r;
`else
    logic level_unused_s;
    assign level_unused_s = level_s;
`endif

    assign period     = period_r;
    assign period_vld = vld_r;
    assign bin_hit    = hit_r;
    assign freq_sel   = sel_r;
    assign locked     = locked_r;
    assign no_signal  = nosig_r;

endmodule

// File: tb/tb_frecuencia_detector.sv
// Directed plus randomized bench for frecuencia_detector with an arithmetic reference model.
module tb_frecuencia_detector;

    localparam int CLK_HZ   = 100_000_000;
    localparam int LOCK_CNT = 4;
    localparam int TIMEOUT  = 10000;
    localparam int CNT_W    = 16;
    localparam int BASE     = 25000;

    logic             clk = 1'b0;
    logic             rst;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic             period_vld;
    logic             bin_hit;
    logic [2:0]       freq_sel;
    logic             locked;
    logic             no_signal;
`ifdef FREQ_DET_DUTY_EN
    logic [CNT_W-1:0] duty_hi;
`endif

    frecuencia_detector #(
        .CLK_HZ   (CLK_HZ),
        .LOCK_CNT (LOCK_CNT),
        .TIMEOUT  (TIMEOUT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .period     (period),
        .period_vld (period_vld),
        .bin_hit    (bin_hit),
        .freq_sel   (freq_sel),
        .locked     (locked),
        .no_signal  (no_signal)
`ifdef FREQ_DET_DUTY_EN
        ,
        .duty_hi    (duty_hi)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_active, m_locked, m_sel, m_cand, m_match, m_miss, m_nosig, m_period, m_hit;
    int last_len, last_hi;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int classify(input int p);
        for (int k = 1; k <= 8; k++) begin
            int pk;
            pk = CLK_HZ / (k * BASE);
            if (p >= pk - pk / 32 && p <= pk + pk / 32) return k - 1;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_active = 0; m_locked = 0; m_sel = 0; m_cand = -1; m_match = 0;
        m_miss = 0; m_nosig = 0; m_period = 0; m_hit = 0; last_len = 0; last_hi = 0;
    endtask

    // Apply one rising edge that ends a period of length p.
    task automatic model_edge(input int p, output bit vld);
        int b;
        if (m_active == 0) begin
            m_active = 1; m_nosig = 0; m_match = 0; m_miss = 0; m_cand = -1;
            vld = 1'b0;
        end else begin
            vld = 1'b1;
            b = classify(p);
            m_period = p;
            m_hit = (b >= 0);
            if (m_locked == 0) begin
                if (b < 0) m_match = 0;
                else if (b == m_cand) m_match++;
                else begin m_cand = b; m_match = 1; end
                if (m_match == LOCK_CNT) begin
                    m_locked = 1; m_sel = b; m_miss = 0; m_match = 0;
                end
            end else begin
                if (b == m_sel) m_miss = 0;
                else m_miss++;
                if (m_miss == LOCK_CNT) begin
                    m_locked = 0; m_miss = 0; m_match = 0; m_cand = -1;
                end
            end
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".period"},    32'(period),    32'(m_period));
        chk({tag, ".bin_hit"},   32'(bin_hit),   32'(m_hit));
        chk({tag, ".locked"},    32'(locked),    32'(m_locked));
        chk({tag, ".freq_sel"},  32'(freq_sel),  32'(m_sel));
        chk({tag, ".no_signal"}, 32'(no_signal), 32'(m_nosig));
    endtask

    // One input period: rise now, fall after hi cycles, next rise after p cycles.
    task automatic gen(input int p, input int hi, input string tag);
        bit ev;
        sig_in = 1'b1;
        model_edge(last_len, ev);
        for (int i = 1; i <= p; i++) begin
            @(negedge clk);
            if (i == 3 || i == 5) chk({tag, ".vld_quiet"}, 32'(period_vld), 32'd0);
            if (i == 4) begin
                chk({tag, ".period_vld"}, 32'(period_vld), 32'(ev));
                check_state(tag);
`ifdef FREQ_DET_DUTY_EN
                if (ev && last_hi == 300)
                    chk({tag, ".duty_hi_300pm1"}, 32'(duty_hi >= 16'd299 && duty_hi <= 16'd301), 32'd1);
`endif
            end
            if (i == hi) sig_in = 1'b0;
        end
        last_len = p;
        last_hi  = hi;
    endtask

    initial begin
        bit ev;
        rst    = 1'b0;
        sig_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset.period_vld", 32'(period_vld), 32'd0);
        check_state("reset");
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 200 kHz: lock to bin 7 on the fifth edge
        for (int n = 0; n < 6; n++) gen(500, 250, "f200k");
        chk("f200k.locked_final", 32'(locked), 32'd1);
        chk("f200k.sel_final", 32'(freq_sel), 32'd7);
        chk("f200k.period_final", 32'(period), 32'd500);

        // Loss of signal after lock
        sig_in = 1'b1;
        model_edge(last_len, ev);
        for (int i = 1; i <= TIMEOUT + 4; i++) begin
            @(negedge clk);
            if (i == 4) begin
                chk("los.period_vld", 32'(period_vld), 32'(ev));
                check_state("los_edge");
            end
            if (i == 250) sig_in = 1'b0;
            if (i == TIMEOUT + 3) begin
                chk("los.pre_no_signal", 32'(no_signal), 32'd0);
                chk("los.pre_locked", 32'(locked), 32'd1);
            end
            if (i == TIMEOUT + 4) begin
                m_active = 0; m_locked = 0; m_nosig = 1; m_match = 0; m_miss = 0;
                chk("los.no_signal", 32'(no_signal), 32'd1);
                chk("los.locked", 32'(locked), 32'd0);
            end
        end
        last_len = 0;

        // 25 kHz lock (first edge also clears no_signal), then 100 kHz unlock/relock
        for (int n = 0; n < 5; n++) gen(4000, 2000, "f25k");
        chk("f25k.locked_final", 32'(locked), 32'd1);
        chk("f25k.sel_final", 32'(freq_sel), 32'd0);
        for (int n = 0; n < 9; n++) gen(1000, 300, "f100k");
        chk("f100k.locked_final", 32'(locked), 32'd1);
        chk("f100k.sel_final", 32'(freq_sel), 32'd3);

        // 60 kHz: never a bin hit
        for (int n = 0; n < 6; n++) gen(1667, 833, "f60k");
        chk("f60k.bin_hit", 32'(bin_hit), 32'd0);
        chk("f60k.locked", 32'(locked), 32'd0);

        // Asynchronous reset in the middle of ACQUIRE
        sig_in = 1'b1;
        repeat (20) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst.period", 32'(period), 32'd0);
        chk("arst.period_vld", 32'(period_vld), 32'd0);
        chk("arst.bin_hit", 32'(bin_hit), 32'd0);
        chk("arst.freq_sel", 32'(freq_sel), 32'd0);
        chk("arst.locked", 32'(locked), 32'd0);
        chk("arst.no_signal", 32'(no_signal), 32'd0);
        sig_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);

        // Window boundaries around 50 kHz (P = 2000, window 62)
        gen(2000, 1000, "tol_a");
        gen(1938, 969, "tol_1938");
        gen(2062, 1031, "tol_2062");
        gen(1937, 968, "tol_1937");
        gen(2063, 1031, "tol_2063");
        gen(2000, 1000, "tol_b");

        // Randomized periods around the higher-frequency bins
        for (int n = 0; n < 12; n++) begin
            int k, pk, w, p;
            k  = int'($urandom_range(8, 4));
            pk = CLK_HZ / (k * BASE);
            w  = pk / 32 + 4;
            p  = pk + int'($urandom_range(2 * w)) - w;
            gen(p, p / 2, "rand");
        end
        gen(600, 300, "final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
